// File: rtl/modulo_io_multicanal_pkg.sv
// Shared encodings for the multi-channel I/O module: OpIO codes, FSM states,
// and the width of the channel field carried in the immediate.
package io_pkg;

  localparam int CH_W = 8;

  typedef enum logic [1:0] {
    IO_NONE = 2'b00,
    IO_IN   = 2'b01,
    IO_OUT  = 2'b10,
    IO_RSV  = 2'b11
  } op_io_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_SET = 2'b01,
    CAPTURE  = 2'b10,
    HALTED   = 2'b11
  } io_state_t;

endpackage

// File: rtl/modulo_io_multicanal_sincroniza_botao.sv
// Raw push-button qualifier: two-flop synchroniser, a counter that only lets
// the filtered level follow after DEB_CYC equal consecutive samples, and a
// one-cycle pulse on each rising edge of the filtered level.
module sincroniza_botao #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEB_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Synchronise, count disagreeing samples, flip the level once enough agree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 != level) begin
        if (cnt == CNT_LIM) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/modulo_io_multicanal.sv
// Multi-channel I/O unit for the single-cycle core: IN stalls the PC until a
// debounced Set press captures a switch bank, OUT writes one of N_OUT latches,
// and a debounced Swap press rotates which latch drives the display.
module modulo_io_multicanal
  import io_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SW_W    = 13,
  parameter int N_IN    = 2,
  parameter int N_OUT   = 4,
  parameter int DEB_CYC = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [N_IN*SW_W-1:0]   Switches,
  input  logic                   Set,
  input  logic                   Swap,
  input  logic [1:0]             OpIO,
  input  logic                   HaltIAS,
  input  logic [DATA_W-1:0]      Imediato,
  input  logic [DATA_W-1:0]      DadosIn,
  output logic                   Halt,
  output logic [DATA_W-1:0]      DataIO,
  output logic [DATA_W-1:0]      OutputData
);

  localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  io_state_t         state;
  io_state_t         state_next;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   ch_reg;
  logic              is_in;
  logic              is_out;
  logic              in_ok;
  logic              set_pulse;
  logic              swap_pulse;
  logic [DATA_W-1:0] bank_sel;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] out_reg  [N_OUT];
  logic [DATA_W-1:0] out_next [N_OUT];
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  sel_next;
  logic [DATA_W-1:0] disp_next;
  logic              unused_imm;

  assign ch         = Imediato[CH_W-1:0];
  assign unused_imm = ^Imediato[DATA_W-1:CH_W];
  assign is_in      = (op_io_t'(OpIO) == IO_IN);
  assign is_out     = (op_io_t'(OpIO) == IO_OUT);
  assign in_ok      = (int'(ch) < N_IN);

  sincroniza_botao #(.DEB_CYC(DEB_CYC)) u_set (
    .clk   (Clock),
    .rst_n (Reset),
    .raw   (Set),
    .pulse (set_pulse)
  );

  sincroniza_botao #(.DEB_CYC(DEB_CYC)) u_swap (
    .clk   (Clock),
    .rst_n (Reset),
    .raw   (Swap),
    .pulse (swap_pulse)
  );

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and the combinational stall; CAPTURE always falls back to IDLE
  always_comb begin
    state_next = state;
    Halt       = 1'b0;
    case (state)
      IDLE: begin
        if (HaltIAS) begin
          state_next = HALTED;
          Halt       = 1'b1;
        end else if (is_in && in_ok) begin
          state_next = WAIT_SET;
          Halt       = 1'b1;
        end
      end
      WAIT_SET: begin
        Halt = 1'b1;
        if (set_pulse) state_next = CAPTURE;
      end
      CAPTURE: state_next = IDLE;
      HALTED:  Halt = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  // Zero-extended switch bank addressed by the channel latched at IN decode
  always_comb begin
    bank_sel = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (int'(ch_reg) == k) bank_sel = DATA_W'(Switches[k*SW_W +: SW_W]);
    end
  end

  // Channel follows the immediate while idle; data is taken on the Set pulse
  always_ff @(posedge Clock) begin
    if (state == IDLE) ch_reg <= ch;
    if (state == WAIT_SET && set_pulse) data_reg <= bank_sel;
  end

  assign DataIO = (state == CAPTURE) ? data_reg : '0;

  // Next latch contents, display select and displayed word
  always_comb begin
    out_next = out_reg;
    if (state == IDLE && is_out) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (int'(ch) == k) out_next[k] = DadosIn;
      end
    end
    sel_next = sel;
    if (swap_pulse) sel_next = (sel == SEL_W'(N_OUT - 1)) ? '0 : sel + 1'b1;
    disp_next = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (int'(sel_next) == k) disp_next = out_next[k];
    end
  end

  // Output latches, select and registered display
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < N_OUT; k++) out_reg[k] <= '0;
      sel        <= '0;
      OutputData <= '0;
    end else begin
      out_reg    <= out_next;
      sel        <= sel_next;
      OutputData <= disp_next;
    end
  end

endmodule

// File: tb/tb_modulo_io_multicanal.sv
// Directed bench for modulo_io_multicanal with default parameters.
module tb_modulo_io_multicanal;

  localparam int DATA_W = 32;
  localparam int SW_W   = 13;
  localparam int N_IN   = 2;
  localparam int N_OUT  = 4;
  localparam int DEB    = 4;
  localparam int LAT    = DEB + 3;

  logic                 clk;
  logic                 rst_n;
  logic [N_IN*SW_W-1:0] switches;
  logic                 set_btn;
  logic                 swap_btn;
  logic [1:0]           op_io;
  logic                 halt_ias;
  logic [DATA_W-1:0]    imm;
  logic [DATA_W-1:0]    dados_in;
  logic                 halt;
  logic [DATA_W-1:0]    data_io;
  logic [DATA_W-1:0]    output_data;

  int tests;
  int failed;

  modulo_io_multicanal #(
    .DATA_W(DATA_W), .SW_W(SW_W), .N_IN(N_IN), .N_OUT(N_OUT), .DEB_CYC(DEB)
  ) dut (
    .Clock      (clk),
    .Reset      (rst_n),
    .Switches   (switches),
    .Set        (set_btn),
    .Swap       (swap_btn),
    .OpIO       (op_io),
    .HaltIAS    (halt_ias),
    .Imediato   (imm),
    .DadosIn    (dados_in),
    .Halt       (halt),
    .DataIO     (data_io),
    .OutputData (output_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press_swap();
    swap_btn = 1'b1;
    tick(LAT);
    swap_btn = 1'b0;
    tick(10);
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    rst_n    = 1'b0;
    switches = '0;
    set_btn  = 1'b0;
    swap_btn = 1'b0;
    op_io    = 2'b00;
    halt_ias = 1'b0;
    imm      = '0;
    dados_in = '0;

    // Reset state
    tick(3);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_dataio", data_io, 32'd0);
    check("rst_output", output_data, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // OUT to channel 1, then one Swap press shows it
    op_io = 2'b10; imm = 32'd1; dados_in = 32'hDEADBEEF;
    #1;
    check("out_no_stall", {31'd0, halt}, 32'd0);
    tick(1);
    op_io = 2'b00;
    #1;
    check("out_sel0_still0", output_data, 32'd0);
    swap_btn = 1'b1;
    tick(LAT - 1);
    check("swap_early", output_data, 32'd0);
    tick(1);
    check("swap_shows_ch1", output_data, 32'hDEADBEEF);
    swap_btn = 1'b0;
    tick(10);
    check("swap_release_hold", output_data, 32'hDEADBEEF);

    // IN channel 1 stalls until a stable Set press
    switches = {13'h1ABC, 13'h0555};
    op_io = 2'b01; imm = 32'd1;
    #1;
    check("in_decode_halt", {31'd0, halt}, 32'd1);
    tick(1);
    tick(50);
    check("in_wait50_halt", {31'd1 & 31'd0, halt}, 32'd1);
    check("in_wait_dataio0", data_io, 32'd0);
    set_btn = 1'b1;
    tick(LAT - 1);
    check("set_early_halt", {31'd0, halt}, 32'd1);
    tick(1);
    check("capture_halt", {31'd0, halt}, 32'd0);
    check("capture_data", data_io, 32'h00001ABC);
    tick(1);
    op_io = 2'b00;
    #1;
    check("after_capture_idle", {31'd0, halt}, 32'd0);
    check("after_capture_data", data_io, 32'd0);
    set_btn = 1'b0;
    tick(10);

    // Bouncing Set during WAIT_SET is rejected, a stable press captures once
    op_io = 2'b01; imm = 32'd0;
    tick(1);
    for (int r = 0; r < 4; r++) begin
      set_btn = 1'b1;
      tick(2);
      set_btn = 1'b0;
      tick(2);
    end
    tick(10);
    check("bounce_halt", {31'd0, halt}, 32'd1);
    check("bounce_no_data", data_io, 32'd0);
    set_btn = 1'b1;
    tick(LAT - 1);
    check("bounce_stable_early", {31'd0, halt}, 32'd1);
    tick(1);
    check("bounce_capture_halt", {31'd0, halt}, 32'd0);
    check("bounce_capture_data", data_io, 32'h00000555);
    op_io = 2'b00;
    tick(1);
    tick(10);
    check("held_set_no_recapture", data_io, 32'd0);
    check("held_set_idle", {31'd0, halt}, 32'd0);
    set_btn = 1'b0;
    tick(10);

    // Out-of-range IN and OUT channels
    op_io = 2'b01; imm = 32'd5;
    #1;
    check("in_ch5_no_halt", {31'd0, halt}, 32'd0);
    check("in_ch5_data0", data_io, 32'd0);
    tick(1);
    check("in_ch5_stays_idle", {31'd0, halt}, 32'd0);
    op_io = 2'b10; imm = 32'd9; dados_in = 32'h12345678;
    tick(1);
    op_io = 2'b00;
    tick(1);
    check("out_ch9_ignored", output_data, 32'hDEADBEEF);

    // Reset pulsed during WAIT_SET
    op_io = 2'b01; imm = 32'd1;
    tick(3);
    check("pre_reset_halt", {31'd0, halt}, 32'd1);
    rst_n = 1'b0; op_io = 2'b00;
    #1;
    check("reset_mid_wait_halt", {31'd0, halt}, 32'd0);
    check("reset_mid_wait_out", output_data, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    op_io = 2'b01; imm = 32'd1;
    tick(10);
    check("post_reset_waits", {31'd0, halt}, 32'd1);
    set_btn = 1'b1;
    tick(LAT);
    check("post_reset_capture", data_io, 32'h00001ABC);
    op_io = 2'b00;
    tick(1);
    set_btn = 1'b0;
    tick(10);

    // Fill the four latches; channel 0 is on display
    for (int k = 0; k < N_OUT; k++) begin
      op_io = 2'b10; imm = k; dados_in = 32'hA0 + k;
      tick(1);
      if (k == 0) check("out_visible_next", output_data, 32'hA0);
    end
    op_io = 2'b00;

    // HaltIAS: permanent stall, OUT/IN ignored, Swap still rotates
    halt_ias = 1'b1;
    tick(1);
    halt_ias = 1'b0;
    #1;
    check("halted_halt", {31'd0, halt}, 32'd1);
    op_io = 2'b10; imm = 32'd0; dados_in = 32'hFF;
    tick(2);
    op_io = 2'b00;
    #1;
    check("halted_out_ignored", output_data, 32'hA0);
    press_swap();
    check("halted_sel1", output_data, 32'hA1);
    press_swap();
    check("halted_sel2", output_data, 32'hA2);
    press_swap();
    check("halted_sel3", output_data, 32'hA3);
    op_io = 2'b01; imm = 32'd0;
    press_swap();
    check("halted_sel_wrap0", output_data, 32'hA0);
    check("halted_still_halt", {31'd0, halt}, 32'd1);
    op_io = 2'b00;
    tick(20);
    check("halted_forever", {31'd0, halt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
